regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- 16-entry x 16-bit general register file with two asynchronous read ports, one write port and a per-register pending-write scoreboard.
- Sits directly downstream of the writeback stage: it consumes that stage's registered wdata_w / dest_w / we_w outputs and commits them.
- Decode reads operands here and registers destinations at issue.
- The stall output tells decode when a source operand still has an in-flight producer.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width; the file holds 2**ADDR_W entries.
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2**CNT_W-1 = 3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- we_w  in  1  writeback write enable, from the writeback stage.
- dest_w  in  ADDR_W  writeback destination register.
- wdata_w  in  DATA_W  writeback data.
- ra_a  in  ADDR_W  read port A address.
- ra_b  in  ADDR_W  read port B address.
- use_a  in  1  decode actually needs operand A (qualifies the hazard check).
- use_b  in  1  decode actually needs operand B.
- iss_valid  in  1  decode is issuing an instruction this cycle.
- iss_we  in  1  the issued instruction writes a register.
- iss_dest  in  ADDR_W  destination of the issued instruction.
- rd_a  out  DATA_W  read data, port A.
- rd_b  out  DATA_W  read data, port B.
- stall  out  1  operand hazard; the issue is not accepted.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset: on a rising clk edge with rst=1, all registers become 0, all pending counters become 0, and sb_err becomes 0. rst overrides every other input in that cycle.
- Write: when we_w=1, regs[dest_w] <= wdata_w at the clock edge.
- Read (combinational, zero latency): rd_x = wdata_w if (we_w and dest_w==ra_x), else regs[ra_x]. This write-through bypass means a writeback and a read of the same register in one cycle returns the new value.
- Effective busy of register r: cnt[r]!=0, except when cnt[r]==1 and a writeback to r happens this cycle; in that case r is not busy, because the bypass supplies the value.
- Stall: stall = (use_a and busy(ra_a)) or (use_b and busy(ra_b)), combinational.
- Issue accept: issue is accepted when iss_valid=1, stall=0 and iss_we=1.
  - The block gates on stall itself; an issue attempted while stall=1 changes no state.
- Counter update per register r, at the clock edge:
  - inc = accepted issue with iss_dest==r.
  - dec = we_w with dest_w==r.
  - inc and dec together: unchanged.
  - inc only: cnt+1. If cnt is already 3, it stays 3 and sb_err <= 1.
  - dec only: cnt-1. If cnt is already 0, it stays 0, sb_err <= 1, and the data write still occurs.
- sb_err is sticky; only reset clears it.
- Counters never wrap.
- An issue whose destination equals its own source is legal; the stall check uses pre-update counters.
- Reset mid-operation: all pending counts are discarded. Writebacks that arrive after reset and target a zero counter raise sb_err. Upstream stages must be flushed by the same rst.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to dest_w==0 are dropped.
  - Reads of ra_x==0 return 0 with no bypass.
  - cnt[0] is never incremented or decremented, so r0 is never busy.
  - Writeback to r0 with cnt 0 does not set sb_err.
- Not defined: register 0 is an ordinary register, identical to the others.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then ra_a=5, ra_b=15 -> rd_a=0, rd_b=0, stall=0, sb_err=0.
- Write and bypass: we_w=1, dest_w=3, wdata_w=16'hBEEF with ra_a=3 in the same cycle -> rd_a=16'hBEEF that cycle; next cycle with we_w=0 -> rd_a still 16'hBEEF.
- Hazard and clear:
  - Issue iss_we=1, iss_dest=7.
  - Next cycle, use_a=1, ra_a=7 -> stall=1; iss_valid held high -> cnt[7] stays 1.
  - Writeback dest_w=7, wdata_w=16'h1234 -> stall=0 in that same cycle and rd_a=16'h1234.
- Simultaneous issue and writeback to r2 with cnt[2]=1 -> cnt[2] stays 1; use_b=1, ra_b=2 on the next cycle -> stall=1.
- Saturation: four accepted issues to r9 with no writeback -> sb_err=1 after the 4th edge; three writebacks to r9 then bring stall (use_a=1, ra_a=9) to 0.
- Underflow: we_w=1, dest_w=4 with cnt[4]=0 -> regs[4] is written and sb_err=1. With REGFILE_R0_ZERO_EN defined, the same write to dest_w=0 -> rd_a (ra_a=0) remains 0 and sb_err stays 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 2**ADDR_W x DATA_W register file with two combinational read ports, one
// write port fed by the writeback stage, and a per-register pending-write scoreboard.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (clears registers, counters, sb_err)
//   we_w       writeback write enable
//   dest_w     writeback destination register
//   wdata_w    writeback data
//   ra_a/ra_b  read addresses for ports A/B
//   use_a/b    operand A/B is actually needed (qualifies the hazard check)
//   iss_valid  decode is issuing an instruction this cycle
//   iss_we     the issued instruction writes a register
//   iss_dest   destination of the issued instruction
//   rd_a/rd_b  read data, with write-through bypass from the writeback port
//   stall      operand hazard; the issue is not accepted
//   sb_err     sticky scoreboard over/underflow error
//
// Optional feature: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero
// (writes dropped, reads return 0, r0 never tracked by the scoreboard).

module regfile_sb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_w,
    input  logic [ADDR_W-1:0] dest_w,
    input  logic [DATA_W-1:0] wdata_w,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    input  logic              use_a,
    input  logic              use_b,
    input  logic              iss_valid,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              stall,
    output logic              sb_err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              sb_err_q, sb_err_d;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   inc;
    logic [NREG-1:0]   dec;
    logic              accept;

    // Read ports with write-through bypass so a same-cycle writeback is visible.
    always_comb begin
        rd_a = regs_q[ra_a];
        rd_b = regs_q[ra_b];
        if (we_w && (dest_w == ra_a)) rd_a = wdata_w;
        if (we_w && (dest_w == ra_b)) rd_b = wdata_w;
`ifdef REGFILE_R0_ZERO_EN
        if (ra_a == '0) rd_a = '0;
        if (ra_b == '0) rd_b = '0;
`endif
    end

    // A register with its last pending write arriving this cycle is not busy:
    // the bypass already supplies the value.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (cnt_q[i] != '0) &&
                      !((cnt_q[i] == CNT_ONE) && we_w && (dest_w == ADDR_W'(i)));
        end
    end

    assign stall  = (use_a && busy[ra_a]) || (use_b && busy[ra_b]);
    assign accept = iss_valid && iss_we && !stall;
    assign sb_err = sb_err_q;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc[i] = accept && (iss_dest == ADDR_W'(i));
            dec[i] = we_w && (dest_w == ADDR_W'(i));
        end
`ifdef REGFILE_R0_ZERO_EN
        inc[0] = 1'b0;
        dec[0] = 1'b0;
`endif
    end

    // Counters saturate at both ends; any clipped update flags sb_err.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) sb_err_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) sb_err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
`ifdef REGFILE_R0_ZERO_EN
        if (we_w && (dest_w != '0)) regs_d[dest_w] = wdata_w;
`else
        if (we_w) regs_d[dest_w] = wdata_w;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with hand-derived
// expectations, then randomized traffic against a behavioural model.

module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we_w;
    logic [3:0]  dest_w;
    logic [15:0] wdata_w;
    logic [3:0]  ra_a, ra_b;
    logic        use_a, use_b;
    logic        iss_valid, iss_we;
    logic [3:0]  iss_dest;
    logic [15:0] rd_a, rd_b;
    logic        stall, sb_err;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    // Behavioural model: register values, in-flight write counts, error flag.
    logic [15:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .we_w      (we_w),
        .dest_w    (dest_w),
        .wdata_w   (wdata_w),
        .ra_a      (ra_a),
        .ra_b      (ra_b),
        .use_a     (use_a),
        .use_b     (use_b),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_dest  (iss_dest),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .stall     (stall),
        .sb_err    (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] m_rd(input int ra);
        if (R0Z && ra == 0) return 16'h0;
        if (we_w && int'(dest_w) == ra) return wdata_w;
        return m_regs[ra];
    endfunction

    function automatic bit m_busy(input int r);
        if (m_cnt[r] == 0) return 1'b0;
        if (m_cnt[r] == 1 && we_w && int'(dest_w) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return (use_a && m_busy(int'(ra_a))) || (use_b && m_busy(int'(ra_b)));
    endfunction

    task automatic model_tick();
        bit acc;
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = 16'h0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
        end else begin
            acc = iss_valid && iss_we && !m_stall();
            for (int r = 0; r < 16; r++) begin
                bit inc, dec;
                inc = acc && int'(iss_dest) == r;
                dec = we_w && int'(dest_w) == r;
                if (R0Z && r == 0) begin
                    inc = 1'b0;
                    dec = 1'b0;
                end
                if (inc && !dec) begin
                    if (m_cnt[r] == 3) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] + 1;
                end else if (dec && !inc) begin
                    if (m_cnt[r] == 0) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 1;
                end
            end
            if (we_w && !(R0Z && dest_w == 4'd0)) m_regs[dest_w] = wdata_w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we_w = 1'b0; dest_w = '0; wdata_w = '0;
        ra_a = '0; ra_b = '0; use_a = 1'b0; use_b = 1'b0;
        iss_valid = 1'b0; iss_we = 1'b0; iss_dest = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ra_a = 4'd5; ra_b = 4'd15; use_a = 1'b1; use_b = 1'b1;
        #1;
        n_tests++; if (rd_a !== 16'h0) begin n_fail++; $display("FAIL reset_rd_a got %h exp 0000", rd_a); end
        n_tests++; if (rd_b !== 16'h0) begin n_fail++; $display("FAIL reset_rd_b got %h exp 0000", rd_b); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    endtask

    task automatic test_write_bypass();
        do_reset();
        we_w = 1'b1; dest_w = 4'd3; wdata_w = 16'hBEEF; ra_a = 4'd3; ra_b = 4'd2;
        #1;
        n_tests++; if (rd_a !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_rd_a got %h exp beef", rd_a); end
        n_tests++; if (rd_b !== 16'h0) begin n_fail++; $display("FAIL bypass_rd_b got %h exp 0000", rd_b); end
        tick();
        we_w = 1'b0;
        #1;
        n_tests++; if (rd_a !== 16'hBEEF) begin n_fail++; $display("FAIL written_rd_a got %h exp beef", rd_a); end
        // The write hit a zero counter, so the underflow flag is set.
        n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL bypass_sb_err got %b exp 1", sb_err); end
    endtask

    task automatic test_hazard();
        do_reset();
        iss_valid = 1'b1; iss_we = 1'b1; iss_dest = 4'd7;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_issue_stall got %b exp 0", stall); end
        tick();
        use_a = 1'b1; ra_a = 4'd7;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall got %b exp 1", stall); end
        tick();
        iss_valid = 1'b0;
        we_w = 1'b1; dest_w = 4'd7; wdata_w = 16'h1234;
        #1;
        // A held issue must not have bumped the count, else this would still stall.
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_clear_stall got %b exp 0", stall); end
        n_tests++; if (rd_a !== 16'h1234) begin n_fail++; $display("FAIL hazard_clear_rd_a got %h exp 1234", rd_a); end
        tick();
        we_w = 1'b0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_after_stall got %b exp 0", stall); end
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL hazard_sb_err got %b exp 0", sb_err); end
    endtask

    task automatic test_simul();
        do_reset();
        iss_valid = 1'b1; iss_we = 1'b1; iss_dest = 4'd2;
        tick();
        we_w = 1'b1; dest_w = 4'd2; wdata_w = 16'h0042;
        tick();
        iss_valid = 1'b0; we_w = 1'b0; use_b = 1'b1; ra_b = 4'd2;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL simul_stall got %b exp 1", stall); end
        n_tests++; if (rd_b !== 16'h0042) begin n_fail++; $display("FAIL simul_rd_b got %h exp 0042", rd_b); end
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL simul_sb_err got %b exp 0", sb_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        iss_valid = 1'b1; iss_we = 1'b1; iss_dest = 4'd9;
        for (int k = 0; k < 3; k++) tick();
        #1;
        n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sat_before_sb_err got %b exp 0", sb_err); end
        tick();
        iss_valid = 1'b0; use_a = 1'b1; ra_a = 4'd9;
        #1;
        n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sat_sb_err got %b exp 1", sb_err); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %b exp 1", stall); end
        for (int k = 0; k < 3; k++) begin
            logic exp_stall;
            exp_stall = (k < 2);
            we_w = 1'b1; dest_w = 4'd9; wdata_w = 16'h9000 + 16'(k);
            #1;
            n_tests++;
            if (stall !== exp_stall) begin
                n_fail++; $display("FAIL sat_drain%0d_stall got %b exp %b", k, stall, exp_stall);
            end
            tick();
        end
        we_w = 1'b0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_drained_stall got %b exp 0", stall); end
        n_tests++; if (rd_a !== 16'h9002) begin n_fail++; $display("FAIL sat_rd_a got %h exp 9002", rd_a); end
    endtask

    task automatic test_underflow();
        do_reset();
        we_w = 1'b1; dest_w = 4'd4; wdata_w = 16'hA5A5;
        tick();
        we_w = 1'b0; ra_a = 4'd4;
        #1;
        n_tests++; if (rd_a !== 16'hA5A5) begin n_fail++; $display("FAIL underflow_rd_a got %h exp a5a5", rd_a); end
        n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL underflow_sb_err got %b exp 1", sb_err); end
        do_reset();
        we_w = 1'b1; dest_w = 4'd0; wdata_w = 16'hFFFF; ra_a = 4'd0;
        #1;
        n_tests++;
        if (rd_a !== (R0Z ? 16'h0 : 16'hFFFF)) begin
            n_fail++; $display("FAIL r0_bypass_rd_a got %h exp %h", rd_a, R0Z ? 16'h0 : 16'hFFFF);
        end
        tick();
        we_w = 1'b0;
        #1;
        n_tests++;
        if (rd_a !== (R0Z ? 16'h0 : 16'hFFFF)) begin
            n_fail++; $display("FAIL r0_rd_a got %h exp %h", rd_a, R0Z ? 16'h0 : 16'hFFFF);
        end
        n_tests++;
        if (sb_err !== !R0Z) begin
            n_fail++; $display("FAIL r0_sb_err got %b exp %b", sb_err, !R0Z);
        end
    endtask

    task automatic test_random();
        logic [15:0] ea, eb;
        bit          es;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            dest_w    = 4'($urandom_range(0, 3));
            we_w      = (m_cnt[dest_w] > 0) ? ($urandom_range(0, 1) == 1)
                                            : ($urandom_range(0, 19) == 0);
            wdata_w   = 16'($urandom);
            ra_a      = 4'($urandom_range(0, 4));
            ra_b      = 4'($urandom_range(0, 4));
            use_a     = $urandom_range(0, 1) == 1;
            use_b     = $urandom_range(0, 1) == 1;
            iss_valid = $urandom_range(0, 2) != 0;
            iss_we    = $urandom_range(0, 3) != 0;
            iss_dest  = 4'($urandom_range(0, 3));
            #1;
            ea = m_rd(int'(ra_a));
            eb = m_rd(int'(ra_b));
            es = m_stall();
            n_tests++; if (rd_a !== ea) begin n_fail++; $display("FAIL rand%0d_rd_a got %h exp %h", n, rd_a, ea); end
            n_tests++; if (rd_b !== eb) begin n_fail++; $display("FAIL rand%0d_rd_b got %h exp %h", n, rd_b, eb); end
            n_tests++; if (stall !== es) begin n_fail++; $display("FAIL rand%0d_stall got %b exp %b", n, stall, es); end
            n_tests++; if (sb_err !== m_err) begin n_fail++; $display("FAIL rand%0d_sb_err got %b exp %b", n, sb_err, m_err); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_bypass();
        test_hazard();
        test_simul();
        test_saturation();
        test_underflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
